// File: rtl/mem_port_arbiter.sv
// Shares one 16-bit memory port between instruction fetch (IF) and data load/store (D).
// D has priority, a starvation counter guarantees IF progress, and reads are tracked to their requester.
`timescale 1ns/1ps
module mem_port_arbiter #(
   parameter int RD_LAT     = 1,
   parameter int STARVE_LIM = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_if_req,
   input  logic [15:0] i_if_addr,
   output logic        o_if_gnt,
   output logic        o_if_rvalid,
   output logic [15:0] o_if_rdata,
   input  logic        i_d_req,
   input  logic        i_d_we,
   input  logic [15:0] i_d_addr,
   input  logic [15:0] i_d_wrdata,
   output logic        o_d_gnt,
   output logic        o_d_rvalid,
   output logic [15:0] o_d_rdata,
   output logic [15:0] o_mem_addr,
   output logic        o_mem_rd,
   output logic        o_mem_wr,
   output logic [15:0] o_mem_wrdata,
   input  logic [15:0] i_mem_rddata,
   output logic        o_busy
);

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_RD_WAIT = 1'b1
   } state_t;

   localparam logic [2:0] LAT_LAST   = 3'(RD_LAT - 1);
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);
   localparam logic [3:0] STARVE_SAT = 4'd15;

   state_t      state_r;
   state_t      state_nxt_s;
   logic [2:0]  lat_cnt_r;
   logic [2:0]  lat_cnt_nxt_s;
   logic [3:0]  starve_cnt_r;
   logic [3:0]  starve_cnt_nxt_s;
   logic        owner_d_r;
   logic        owner_d_nxt_s;

   logic        ret_s;
   logic        may_issue_s;
   logic        starve_hit_s;
   logic        d_win_s;
   logic        if_win_s;
   logic        rd_issue_s;

   // Arbitration: return-cycle detection and winner selection; reset forces everything idle.
   always_comb begin
      ret_s        = 1'b0;
      may_issue_s  = 1'b0;
      starve_hit_s = 1'b0;
      d_win_s      = 1'b0;
      if_win_s     = 1'b0;
      rd_issue_s   = 1'b0;
      if (reset) begin
         ret_s = 1'b0;
      end else begin
         ret_s        = (state_r == ST_RD_WAIT) && (lat_cnt_r == LAT_LAST);
         may_issue_s  = (state_r == ST_IDLE) || ret_s;
         starve_hit_s = i_if_req && (starve_cnt_r >= STARVE_MAX);
         d_win_s      = may_issue_s && i_d_req && !starve_hit_s;
         if_win_s     = may_issue_s && !d_win_s && i_if_req;
         rd_issue_s   = if_win_s || (d_win_s && !i_d_we);
      end
   end

   // Grants, memory strobes and read-data return; read data passes straight through.
   always_comb begin
      o_if_gnt     = if_win_s;
      o_d_gnt      = d_win_s;
      o_if_rvalid  = ret_s && !owner_d_r;
      o_d_rvalid   = ret_s && owner_d_r;
      o_mem_addr   = 16'h0000;
      o_mem_rd     = 1'b0;
      o_mem_wr     = 1'b0;
      o_mem_wrdata = 16'h0000;
      o_busy       = !reset && (state_r == ST_RD_WAIT);
      if (reset) begin
         o_if_rdata = 16'h0000;
         o_d_rdata  = 16'h0000;
      end else begin
         o_if_rdata = i_mem_rddata;
         o_d_rdata  = i_mem_rddata;
      end
      if (d_win_s) begin
         o_mem_addr = i_d_addr;
         if (i_d_we) begin
            o_mem_wr     = 1'b1;
            o_mem_wrdata = i_d_wrdata;
         end else begin
            o_mem_rd = 1'b1;
         end
      end else if (if_win_s) begin
         o_mem_addr = i_if_addr;
         o_mem_rd   = 1'b1;
      end else begin
         o_mem_addr = 16'h0000;
      end
   end

   // Next-state: a new read may be issued in the return cycle of the previous one.
   always_comb begin
      state_nxt_s   = state_r;
      lat_cnt_nxt_s = lat_cnt_r;
      owner_d_nxt_s = owner_d_r;
      if (rd_issue_s) begin
         state_nxt_s   = ST_RD_WAIT;
         lat_cnt_nxt_s = 3'd0;
         owner_d_nxt_s = d_win_s;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_nxt_s   = ST_IDLE;
               lat_cnt_nxt_s = 3'd0;
            end
            ST_RD_WAIT: begin
               if (ret_s) begin
                  state_nxt_s   = ST_IDLE;
                  lat_cnt_nxt_s = 3'd0;
               end else begin
                  state_nxt_s   = ST_RD_WAIT;
                  lat_cnt_nxt_s = lat_cnt_r + 3'd1;
               end
            end
            default: begin
               state_nxt_s   = ST_IDLE;
               lat_cnt_nxt_s = 3'd0;
            end
         endcase
      end
   end

   // Starvation counter: counts issue opportunities lost by a waiting IF request.
   always_comb begin
      if (!i_if_req || if_win_s) begin
         starve_cnt_nxt_s = 4'd0;
      end else if (may_issue_s && (starve_cnt_r != STARVE_SAT)) begin
         starve_cnt_nxt_s = starve_cnt_r + 4'd1;
      end else begin
         starve_cnt_nxt_s = starve_cnt_r;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         lat_cnt_r    <= 3'd0;
         starve_cnt_r <= 4'd0;
         owner_d_r    <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         lat_cnt_r    <= lat_cnt_nxt_s;
         starve_cnt_r <= starve_cnt_nxt_s;
         owner_d_r    <= owner_d_nxt_s;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives three arbiters (RD_LAT 1, 2, 3) with shared stimulus and compares each cycle
// against a countdown-based reference model, plus directed scenario checks.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int N   = 3;
   localparam int LIM = 4;

   logic        clk;
   logic        reset;
   logic        if_req;
   logic [15:0] if_addr;
   logic        d_req;
   logic        d_we;
   logic [15:0] d_addr;
   logic [15:0] d_wrdata;
   logic [15:0] mem_rddata;

   logic [N-1:0] if_gnt, if_rvalid, d_gnt, d_rvalid, mem_rd, mem_wr, busy;
   logic [15:0]  if_rdata [N];
   logic [15:0]  d_rdata [N];
   logic [15:0]  mem_addr [N];
   logic [15:0]  mem_wrdata [N];

   int m_rem [N];
   int m_starve [N];
   logic m_own_d [N];

   int n_assert = 0;
   int n_fail   = 0;

   for (genvar g = 0; g < N; g++) begin : g_dut
      mem_port_arbiter #(.RD_LAT(g + 1), .STARVE_LIM(LIM)) dut (
         .clk          (clk),
         .reset        (reset),
         .i_if_req     (if_req),
         .i_if_addr    (if_addr),
         .o_if_gnt     (if_gnt[g]),
         .o_if_rvalid  (if_rvalid[g]),
         .o_if_rdata   (if_rdata[g]),
         .i_d_req      (d_req),
         .i_d_we       (d_we),
         .i_d_addr     (d_addr),
         .i_d_wrdata   (d_wrdata),
         .o_d_gnt      (d_gnt[g]),
         .o_d_rvalid   (d_rvalid[g]),
         .o_d_rdata    (d_rdata[g]),
         .o_mem_addr   (mem_addr[g]),
         .o_mem_rd     (mem_rd[g]),
         .o_mem_wr     (mem_wr[g]),
         .o_mem_wrdata (mem_wrdata[g]),
         .i_mem_rddata (mem_rddata),
         .o_busy       (busy[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   // Reference arbitration: m_rem = cycles until the outstanding read returns (0 = nothing pending).
   function automatic void arb(input int k, output logic ret, output logic may,
                               output logic dw, output logic iw);
      ret = (m_rem[k] == 1);
      may = (m_rem[k] <= 1);
      dw  = may && d_req && !(if_req && (m_starve[k] >= LIM));
      iw  = may && !dw && if_req;
   endfunction

   task automatic model_check();
      for (int k = 0; k < N; k++) begin
         logic ret, may, dw, iw;
         logic [15:0] e_addr, e_wdat, e_rdat;
         logic e_rd, e_wr, e_busy;
         arb(k, ret, may, dw, iw);
         e_addr = dw ? d_addr : (iw ? if_addr : 16'h0000);
         e_rd   = iw || (dw && !d_we);
         e_wr   = dw && d_we;
         e_wdat = (dw && d_we) ? d_wrdata : 16'h0000;
         e_busy = (m_rem[k] > 0);
         e_rdat = mem_rddata;
         if (reset) begin
            ret = 1'b0; dw = 1'b0; iw = 1'b0; e_addr = 16'h0000; e_rd = 1'b0;
            e_wr = 1'b0; e_wdat = 16'h0000; e_busy = 1'b0; e_rdat = 16'h0000;
         end
         chk("if_gnt", k, if_gnt[k], iw);
         chk("d_gnt", k, d_gnt[k], dw);
         chk("if_rvalid", k, if_rvalid[k], ret && !m_own_d[k]);
         chk("d_rvalid", k, d_rvalid[k], ret && m_own_d[k]);
         chk("if_rdata", k, if_rdata[k], e_rdat);
         chk("d_rdata", k, d_rdata[k], e_rdat);
         chk("mem_addr", k, mem_addr[k], e_addr);
         chk("mem_rd", k, mem_rd[k], e_rd);
         chk("mem_wr", k, mem_wr[k], e_wr);
         chk("mem_wrdata", k, mem_wrdata[k], e_wdat);
         chk("busy", k, busy[k], e_busy);
      end
   endtask

   task automatic model_update();
      for (int k = 0; k < N; k++) begin
         logic ret, may, dw, iw;
         if (reset) begin
            m_rem[k] = 0; m_starve[k] = 0; m_own_d[k] = 1'b0;
         end else begin
            arb(k, ret, may, dw, iw);
            if (!if_req || iw) m_starve[k] = 0;
            else if (may && m_starve[k] < 15) m_starve[k] = m_starve[k] + 1;
            if (iw || (dw && !d_we)) begin
               m_rem[k] = k + 1;
               m_own_d[k] = dw;
            end else if (m_rem[k] > 0) begin
               m_rem[k] = m_rem[k] - 1;
            end
         end
      end
   endtask

   task automatic settle();
      #3;
      model_check();
   endtask

   task automatic adv();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         settle();
         adv();
      end
   endtask

   initial begin
      for (int k = 0; k < N; k++) begin
         m_rem[k] = 0; m_starve[k] = 0; m_own_d[k] = 1'b0;
      end
      reset = 1'b1; if_req = 1'b0; if_addr = 16'h0000; d_req = 1'b0; d_we = 1'b0;
      d_addr = 16'h0000; d_wrdata = 16'h0000; mem_rddata = 16'h0000;

      // Reset state
      settle();
      for (int k = 0; k < N; k++) begin
         chk("rst_outs", k, {if_gnt[k], d_gnt[k], if_rvalid[k], d_rvalid[k], mem_rd[k], mem_wr[k], busy[k]}, 16'h0000);
         chk("rst_addr", k, mem_addr[k], 16'h0000);
      end
      adv();
      drain(1);
      reset = 1'b0;

      // 1: single IF read, RD_LAT=1
      if_req = 1'b1; if_addr = 16'h0010;
      settle();
      chk("t1_if_gnt", 0, if_gnt[0], 1'b1);
      chk("t1_mem_addr", 0, mem_addr[0], 16'h0010);
      chk("t1_mem_rd", 0, mem_rd[0], 1'b1);
      adv();
      if_req = 1'b0; if_addr = 16'h0000; mem_rddata = 16'h1234;
      settle();
      chk("t1_if_rvalid", 0, if_rvalid[0], 1'b1);
      chk("t1_if_rdata", 0, if_rdata[0], 16'h1234);
      adv();
      mem_rddata = 16'h0000;
      drain(4);

      // 2: IF read collides with D store
      if_req = 1'b1; if_addr = 16'h0020;
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h8000; d_wrdata = 16'hBEEF;
      settle();
      chk("t2_d_gnt", 0, d_gnt[0], 1'b1);
      chk("t2_if_gnt", 0, if_gnt[0], 1'b0);
      chk("t2_mem_wr", 0, mem_wr[0], 1'b1);
      chk("t2_mem_addr", 0, mem_addr[0], 16'h8000);
      chk("t2_mem_wrdata", 0, mem_wrdata[0], 16'hBEEF);
      adv();
      d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0000; d_wrdata = 16'h0000;
      settle();
      chk("t2_if_gnt2", 0, if_gnt[0], 1'b1);
      chk("t2_mem_addr2", 0, mem_addr[0], 16'h0020);
      adv();
      if_req = 1'b0; if_addr = 16'h0000;
      drain(4);

      // 3: D load stream starves IF until the limit
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h4444;
      if_req = 1'b1; if_addr = 16'h0030;
      for (int i = 0; i < 6; i++) begin
         settle();
         chk("t3_if_gnt", i, if_gnt[0], (i == LIM));
         chk("t3_d_gnt", i, d_gnt[0], (i != LIM));
         adv();
         if (i == LIM) begin
            if_req = 1'b0; if_addr = 16'h0000;
         end
      end
      d_req = 1'b0; d_addr = 16'h0000;
      drain(4);

      // 4: back-to-back IF reads with RD_LAT=3 (instance 2)
      if_req = 1'b1; if_addr = 16'h0000;
      settle();
      chk("t4_if_gnt", 0, if_gnt[2], 1'b1);
      chk("t4_busy", 0, busy[2], 1'b0);
      adv();
      if_addr = 16'h0002;
      for (int j = 1; j <= 6; j++) begin
         settle();
         chk("t4_if_gnt", j, if_gnt[2], (j == 3));
         chk("t4_if_rvalid", j, if_rvalid[2], (j == 3) || (j == 6));
         chk("t4_busy", j, busy[2], 1'b1);
         adv();
         if (j == 3) begin
            if_req = 1'b0; if_addr = 16'h0000;
         end
      end
      settle();
      chk("t4_busy_end", 7, busy[2], 1'b0);
      adv();
      drain(4);

      // 5: reset while a D load is outstanding (instance 1, RD_LAT=2)
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h4000;
      settle();
      chk("t5_d_gnt", 1, d_gnt[1], 1'b1);
      adv();
      d_req = 1'b0; d_addr = 16'h0000; reset = 1'b1;
      settle();
      adv();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("t5_d_rvalid", i, d_rvalid[1], 1'b0);
         chk("t5_outs", i, {if_gnt[1], d_gnt[1], if_rvalid[1], mem_rd[1], mem_wr[1], busy[1]}, 16'h0000);
         adv();
      end

      // 6: idle for ten cycles
      for (int i = 0; i < 10; i++) begin
         settle();
         for (int k = 0; k < N; k++)
            chk("t6_idle", k, {if_gnt[k], d_gnt[k], if_rvalid[k], d_rvalid[k], mem_rd[k], mem_wr[k], busy[k]}, 16'h0000);
         adv();
      end

      // Randomised traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         reset      = ($urandom_range(0, 39) == 0);
         if_req     = ($urandom_range(0, 3) != 0);
         if_addr    = 16'($urandom());
         d_req      = ($urandom_range(0, 2) != 0);
         d_we       = 1'($urandom());
         d_addr     = 16'($urandom());
         d_wrdata   = 16'($urandom());
         mem_rddata = 16'($urandom());
         settle();
         adv();
      end
      reset = 1'b0; if_req = 1'b0; d_req = 1'b0;
      drain(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
